// File: rtl/mdu_div_ctrl_pkg.sv
// Shared constants for the multi-cycle divide controller: state encodings,
// default operand width, {HI, LO} result width and pipeline stall levels.
package mdu_div_ctrl_pkg;

  localparam int DIV_WIDTH    = 32;
  localparam int DIV_CNT_W    = 6;
  localparam int DIV_RESULT_W = 2 * DIV_WIDTH;

  // Stall request levels understood by the pipeline stall controller.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DIV_ZERO = 2'b01,
    ST_DIV_ON   = 2'b10,
    ST_DIV_END  = 2'b11
  } div_state_e;

endpackage

// File: rtl/mdu_div_ctrl_if.sv
// EX <-> divider handshake bundle. EX drives the request side (master),
// the divide controller answers with result, ready and stall (slave).
interface mdu_div_ctrl_if
  import mdu_div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic                 start_i;
  logic                 signed_i;
  logic                 annul_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 stallreq_o;

  modport master (
    output start_i,
    output signed_i,
    output annul_i,
    output opdata1_i,
    output opdata2_i,
    input  result_o,
    input  ready_o,
    input  stallreq_o
  );

  modport slave (
    input  start_i,
    input  signed_i,
    input  annul_i,
    input  opdata1_i,
    input  opdata2_i,
    output result_o,
    output ready_o,
    output stallreq_o
  );

endinterface

// File: rtl/mdu_div_ctrl_div_step.sv
// One radix-2 restoring divide iteration: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep or restore.
module mdu_div_ctrl_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_dvd_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  // The shifted value is one bit wider than the stored remainder so the
  // borrow of the trial subtraction lands in its own top bit.
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  // Trial subtraction and restore decision.
  always_comb begin
    w_shift = {i_rem, i_dvd_bit};
    w_diff  = w_shift - {2'b00, i_dvs};
    if (w_diff[WIDTH+1] == 1'b0) begin
      o_qbit = 1'b1;
      o_rem  = w_diff[WIDTH:0];
    end else begin
      o_qbit = 1'b0;
      o_rem  = w_shift[WIDTH:0];
    end
  end

endmodule

// File: rtl/mdu_div_ctrl.sv
// Multi-cycle DIV/DIVU controller beside EX. Runs WIDTH restoring iterations
// on operand magnitudes, sign-corrects, and presents {remainder, quotient}
// for the HI/LO write path while holding the pipeline with a stall request.
module mdu_div_ctrl
  import mdu_div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  mdu_div_ctrl_if.slave bus
);

  // Two's complement negation at operand width.
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Unsigned magnitude; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? twos_neg(v) : v;
  endfunction

  div_state_e          r_state;
  div_state_e          w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [WIDTH:0]      r_rem;
  logic [WIDTH-1:0]    r_dvd;
  logic [WIDTH-1:0]    r_dvs;
  logic                r_signed;
  logic                r_sign1;
  logic                r_sign2;
  logic [2*WIDTH-1:0]  r_result;
  logic                r_ready;

  logic                w_go;
  logic                w_neg1;
  logic                w_neg2;
  logic [WIDTH-1:0]    w_mag1;
  logic [WIDTH-1:0]    w_mag2;
  logic                w_dvs_zero;
  logic                w_last;
  logic [WIDTH:0]      w_step_rem;
  logic [WIDTH-1:0]    w_step_dvd;
  logic [WIDTH-1:0]    w_step_dvs;
  logic [WIDTH:0]      w_next_rem;
  logic                w_qbit;
  logic [WIDTH-1:0]    w_next_dvd;
  logic [WIDTH-1:0]    w_quo_fix;
  logic [WIDTH-1:0]    w_rem_fix;

  assign w_go       = bus.start_i & ~bus.annul_i;
  assign w_neg1     = bus.signed_i & bus.opdata1_i[WIDTH-1];
  assign w_neg2     = bus.signed_i & bus.opdata2_i[WIDTH-1];
  assign w_mag1     = magnitude(bus.opdata1_i, w_neg1);
  assign w_mag2     = magnitude(bus.opdata2_i, w_neg2);
  assign w_dvs_zero = (bus.opdata2_i == {WIDTH{1'b0}});
  // The start edge performs the first iteration, so DIV_ON finishes after
  // WIDTH-1 further edges; cnt counts the DIV_ON iterations.
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 2));

  // Feed the iteration from the live operands on the start edge, from the
  // working registers afterwards.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_step_rem = {(WIDTH+1){1'b0}};
      w_step_dvd = w_mag1;
      w_step_dvs = w_mag2;
    end else begin
      w_step_rem = r_rem;
      w_step_dvd = r_dvd;
      w_step_dvs = r_dvs;
    end
  end

  mdu_div_ctrl_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem     (w_step_rem),
    .i_dvd_bit (w_step_dvd[WIDTH-1]),
    .i_dvs     (w_step_dvs),
    .o_rem     (w_next_rem),
    .o_qbit    (w_qbit)
  );

  // Quotient bits enter the dividend register from the bottom as its bits
  // leave from the top.
  assign w_next_dvd = {w_step_dvd[WIDTH-2:0], w_qbit};

  // Sign correction applied on the completing iteration.
  always_comb begin
    if (r_signed & (r_sign1 ^ r_sign2)) begin
      w_quo_fix = twos_neg(w_next_dvd);
    end else begin
      w_quo_fix = w_next_dvd;
    end
    if (r_signed & r_sign1) begin
      w_rem_fix = twos_neg(w_next_rem[WIDTH-1:0]);
    end else begin
      w_rem_fix = w_next_rem[WIDTH-1:0];
    end
  end

  // Next-state decode; annul beats completion in every busy state.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          if (w_dvs_zero) begin
            w_next_state = ST_DIV_ZERO;
          end else begin
            w_next_state = ST_DIV_ON;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_DIV_ZERO: begin
        if (bus.annul_i) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DIV_END;
        end
      end
      ST_DIV_ON: begin
        if (bus.annul_i) begin
          w_next_state = ST_IDLE;
        end else if (w_last) begin
          w_next_state = ST_DIV_END;
        end else begin
          w_next_state = ST_DIV_ON;
        end
      end
      ST_DIV_END: begin
        if (bus.annul_i | ~bus.start_i) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DIV_END;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register and registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state == ST_DIV_END);
    end
  end

  // Operand capture, iteration datapath, counter and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_rem    <= {(WIDTH+1){1'b0}};
      r_dvd    <= {WIDTH{1'b0}};
      r_dvs    <= {WIDTH{1'b0}};
      r_signed <= 1'b0;
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_result <= {(2*WIDTH){1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_signed <= bus.signed_i;
            r_sign1  <= w_neg1;
            r_sign2  <= w_neg2;
            r_dvs    <= w_mag2;
            r_cnt    <= {CNT_W{1'b0}};
            if (w_dvs_zero) begin
              r_rem <= {(WIDTH+1){1'b0}};
              r_dvd <= {WIDTH{1'b0}};
            end else begin
              r_rem <= w_next_rem;
              r_dvd <= w_next_dvd;
            end
          end
        end
        ST_DIV_ZERO: begin
          r_cnt <= {CNT_W{1'b0}};
          if (!bus.annul_i) begin
            r_result <= {(2*WIDTH){1'b0}};
          end
        end
        ST_DIV_ON: begin
          if (bus.annul_i) begin
            r_cnt <= {CNT_W{1'b0}};
          end else begin
            r_rem <= w_next_rem;
            r_dvd <= w_next_dvd;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_result <= {w_rem_fix, w_quo_fix};
            end
          end
        end
        ST_DIV_END: begin
          r_cnt <= {CNT_W{1'b0}};
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.result_o   = r_result;
  assign bus.ready_o    = r_ready;
  assign bus.stallreq_o = (w_go & ~rst & (r_state != ST_DIV_END)) ? STOP : NO_STOP;

endmodule
